// File: rtl/direct_mapped_cache.sv
//==============================================================================
// Module      : direct_mapped_cache
// Description : Direct-mapped, write-back, write-allocate cache with a
//               block-streaming memory port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module direct_mapped_cache #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH        = 2
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           cpu_req,
    input  logic                                           cpu_we,
    input  logic [ADDR_WIDTH-1:0]                          cpu_addr,
    input  logic [DATA_WIDTH-1:0]                          cpu_wdata,
    output logic [DATA_WIDTH-1:0]                          cpu_rdata,
    output logic                                           cpu_ready,
    output logic [ADDR_WIDTH-1:0]                          mem_addr,
    output logic [(1<<BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0]  mem_block_din,
    output logic                                           mem_we,
    input  logic                                           mem_valid,
    input  logic [DATA_WIDTH-1:0]                          mem_dout
);

    localparam int c_block_size = 1 << BLOCK_OFFSET_WIDTH;
    localparam int c_num_lines  = 1 << INDEX_WIDTH;
    localparam int c_tag_width  = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int c_cnt_width  = BLOCK_OFFSET_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RESP       = 3'd1,
        WB_SETUP   = 3'd2,
        WB         = 3'd3,
        FILL_SETUP = 3'd4,
        FILL       = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [DATA_WIDTH-1:0]   r_data [c_num_lines][c_block_size];
    logic [c_tag_width-1:0]  r_tag  [c_num_lines];
    logic [c_num_lines-1:0]  r_valid;
    logic [c_num_lines-1:0]  r_dirty;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [c_cnt_width-1:0]  r_cnt;

    logic [BLOCK_OFFSET_WIDTH-1:0] w_offset;
    logic [INDEX_WIDTH-1:0]        w_index;
    logic [c_tag_width-1:0]        w_tag;
    logic                          w_hit;
    logic                          w_victim_dirty;
    logic                          w_last_beat;
    logic [ADDR_WIDTH-1:0]         w_victim_addr;
    logic [ADDR_WIDTH-1:0]         w_fill_addr;

    assign w_offset       = cpu_addr[BLOCK_OFFSET_WIDTH-1:0];
    assign w_index        = cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_tag          = cpu_addr[ADDR_WIDTH-1 -: c_tag_width];
    assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
    assign w_last_beat    = mem_valid && (r_cnt == c_cnt_width'(c_block_size - 1));
    assign w_victim_addr  = {r_tag[w_index], w_index, {BLOCK_OFFSET_WIDTH{1'b0}}};
    assign w_fill_addr    = {w_tag, w_index, {BLOCK_OFFSET_WIDTH{1'b0}}};

    assign cpu_rdata = r_rdata;
    assign cpu_ready = (r_state == RESP);
    assign mem_we    = (r_state == WB_SETUP) || (r_state == WB);
    assign mem_addr  = r_mem_addr;

    // The victim line is read straight from the array; it cannot change during WB.
    for (genvar i = 0; i < c_block_size; i++) begin : g_din
        assign mem_block_din[i*DATA_WIDTH +: DATA_WIDTH] = r_data[w_index][i];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    if (w_hit)               w_next = RESP;
                    else if (w_victim_dirty) w_next = WB_SETUP;
                    else                     w_next = FILL_SETUP;
                end
            end
            RESP:       w_next = IDLE;
            WB_SETUP:   w_next = WB;
            WB:         if (w_last_beat) w_next = FILL_SETUP;
            FILL_SETUP: w_next = FILL;
            FILL:       if (w_last_beat) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // Setup states present the inverted target so the memory always sees a new address.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        if (w_hit) begin
                            if (cpu_we) r_dirty[w_index] <= 1'b1;
                            else        r_rdata <= r_data[w_index][w_offset];
                        end else if (w_victim_dirty) begin
                            r_mem_addr <= ~w_victim_addr;
                        end else begin
                            r_mem_addr <= ~w_fill_addr;
                        end
                    end
                end
                WB_SETUP: begin
                    r_mem_addr <= w_victim_addr;
                    r_cnt      <= '0;
                end
                WB: begin
                    if (mem_valid) r_cnt <= r_cnt + c_cnt_width'(1);
                    if (w_last_beat) begin
                        r_dirty[w_index] <= 1'b0;
                        r_mem_addr       <= ~w_fill_addr;
                    end
                end
                FILL_SETUP: begin
                    r_mem_addr <= w_fill_addr;
                    r_cnt      <= '0;
                end
                FILL: begin
                    if (mem_valid) r_cnt <= r_cnt + c_cnt_width'(1);
                    if (w_last_beat) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line contents and tags carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (r_state == IDLE && cpu_req && w_hit && cpu_we)
                r_data[w_index][w_offset] <= cpu_wdata;
            if (r_state == FILL && mem_valid) begin
                r_data[w_index][r_cnt[BLOCK_OFFSET_WIDTH-1:0]] <= mem_dout;
                if (w_last_beat) r_tag[w_index] <= w_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_direct_mapped_cache.sv
//==============================================================================
// Module      : tb_direct_mapped_cache
// Description : Scoreboard bench for direct_mapped_cache with a streaming
//               block-memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_direct_mapped_cache;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [9:0]    cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic [9:0]    mem_addr;
    logic [255:0]  mem_block_din;
    logic          mem_we;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_dout = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    int          id_q[$];
    int          next_id = 0;

    direct_mapped_cache dut (
        .clk           (clk),
        .rstn          (rstn),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ready     (cpu_ready),
        .mem_addr      (mem_addr),
        .mem_block_din (mem_block_din),
        .mem_we        (mem_we),
        .mem_valid     (mem_valid),
        .mem_dout      (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory: waits for a stable address, then streams 8 words; writes when mem_we.
    logic [31:0] mem [1024];
    logic [9:0]  m_last = 10'h3FF;
    int          m_stable = 0;
    int          m_beat = 0;
    bit          m_served = 1'b0;
    bit          m_stream = 1'b0;

    initial for (int a = 0; a < 1024; a++) mem[a] = 32'(a);

    always @(posedge clk) begin
        if (mem_addr !== m_last) begin
            m_last    <= mem_addr;
            m_stable  <= 0;
            m_served  <= 1'b0;
            m_stream  <= 1'b0;
            mem_valid <= 1'b0;
        end else if (m_stream) begin
            if (mem_we) mem[int'(m_last) + m_beat] <= mem_block_din[m_beat*32 +: 32];
            if (m_beat == 7) begin
                m_stream  <= 1'b0;
                m_served  <= 1'b1;
                mem_valid <= 1'b0;
            end else begin
                m_beat   <= m_beat + 1;
                mem_dout <= mem[int'(m_last) + m_beat + 1];
            end
        end else if (!m_served) begin
            if (m_stable == 15) begin
                m_stream  <= 1'b1;
                m_beat    <= 0;
                mem_valid <= 1'b1;
                mem_dout  <= mem[m_last];
            end else begin
                m_stable <= m_stable + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops one scoreboard entry per cpu_ready pulse.
    always @(negedge clk) begin
        if (rstn && cpu_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
            end else begin
                logic [31:0] e;
                bit          c;
                int          id;
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                id = id_q.pop_front();
                if (c) begin
                    n_vec++;
                    if (cpu_rdata !== e) begin
                        n_err++;
                        $display("FAIL rdata_req%0d: got %h, expected %h", id, cpu_rdata, e);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp, input logic [9:0] setup_addr,
                          output int cyc, output int we_cyc, output int setup_cyc);
        cyc = 0; we_cyc = 0; setup_cyc = 0;
        exp_q.push_back(exp);
        chk_q.push_back(!we);
        id_q.push_back(next_id);
        next_id++;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_we === 1'b1) we_cyc++;
            if (mem_addr === setup_addr) setup_cyc++;
            if (cpu_ready === 1'b1) break;
            if (cyc > 300) begin
                check("req_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {31'd0, cpu_ready}, 32'd0);
    endtask

    int cyc, wec, suc, beats;
    logic [9:0] a_before;

    initial begin
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  {22'd0, mem_addr},  32'd0);
        check("rst_cpu_rdata", cpu_rdata,          32'd0);

        // Cold read: fill only, never a write-back.
        do_req(1'b0, 10'h013, '0, 32'h0000_0013, 10'h3EF, cyc, wec, suc);
        check("cold_no_we",    32'(wec), 32'd0);
        check("cold_setup",    32'(suc), 32'd1);

        // Hit read: one cycle, memory address untouched.
        a_before = mem_addr;
        do_req(1'b0, 10'h015, '0, 32'h0000_0015, 10'h3EF, cyc, wec, suc);
        check("hit_latency",   32'(cyc), 32'd1);
        check("hit_addr_hold", {22'd0, mem_addr}, {22'd0, a_before});
        check("hit_addr_val",  {22'd0, mem_addr}, 32'h010);

        do_req(1'b1, 10'h015, 32'hDEAD_BEEF, '0, 10'h3EF, cyc, wec, suc);
        check("whit_latency",  32'(cyc), 32'd1);

        // Conflict miss with a dirty victim.
        do_req(1'b0, 10'h095, '0, 32'h0000_0095, 10'h3EF, cyc, wec, suc);
        check("wb_seen",       32'(wec > 0), 32'd1);
        check("wb_setup_once", 32'(suc), 32'd1);
        check("wb_mem_word",   mem[10'h015], 32'hDEAD_BEEF);
        check("wb_mem_other",  mem[10'h013], 32'h0000_0013);

        // Clean victim: fill only.
        do_req(1'b0, 10'h015, '0, 32'hDEAD_BEEF, 10'h3EF, cyc, wec, suc);
        check("clean_no_we",   32'(wec), 32'd0);
        check("fill_setup",    32'(suc), 32'd1);

        // Reset in the middle of a fill.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0A0;
        beats = 0;
        for (int i = 0; i < 300 && beats < 4; i++) begin
            @(negedge clk);
            if (mem_valid === 1'b1 && mem_addr === 10'h0A0) beats++;
        end
        check("fill_beats_seen", 32'(beats), 32'd4);
        rstn = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort_ready",   {31'd0, cpu_ready}, 32'd0);
        check("abort_mem_we",  {31'd0, mem_we},    32'd0);
        check("abort_mem_addr",{22'd0, mem_addr},  32'd0);

        do_req(1'b0, 10'h013, '0, 32'h0000_0013, 10'h3EF, cyc, wec, suc);
        check("post_rst_miss", 32'(cyc > 1), 32'd1);
        check("post_rst_no_we",32'(wec), 32'd0);
        do_req(1'b0, 10'h015, '0, 32'hDEAD_BEEF, 10'h3EF, cyc, wec, suc);
        check("post_rst_hit",  32'(cyc), 32'd1);

        // Write-allocate miss, then evict it and read it back from memory.
        do_req(1'b1, 10'h123, 32'h0000_0055, '0, 10'h2DF, cyc, wec, suc);
        check("wmiss_latency", 32'(cyc > 1), 32'd1);
        check("wmiss_setup",   32'(suc), 32'd1);
        do_req(1'b0, 10'h0A3, '0, 32'h0000_00A3, 10'h2DF, cyc, wec, suc);
        check("wb2_seen",      32'(wec > 0), 32'd1);
        check("wb2_mem_word",  mem[10'h123], 32'h0000_0055);
        do_req(1'b0, 10'h123, '0, 32'h0000_0055, 10'h2DF, cyc, wec, suc);
        check("reload_no_we",  32'(wec), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width.
REQ-003 SHALL have parameter BLOCK_OFFSET_WIDTH, default 3, log2 of words per line (BLOCK_SIZE = 8).
REQ-004 SHALL have parameter INDEX_WIDTH, default 2, log2 of line count (4 lines); tag width = ADDR_WIDTH-INDEX_WIDTH-BLOCK_OFFSET_WIDTH.
REQ-005 SHALL have one clock and one reset; reset is synchronous, active-low:
- clk  in  1  rising-edge clock for all state
- rstn  in  1  synchronous active-low reset
- cpu_req  in  1  request; held with addr/we/wdata stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_WIDTH  block memory address, offset bits 0
- mem_block_din  out  BLOCK_SIZE*DATA_WIDTH  write-back line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- mem_we  out  1  block write enable
- mem_valid  in  1  memory word strobe
- mem_dout  in  DATA_WIDTH  memory word, valid while mem_valid=1

Function
REQ-006 SHALL be direct-mapped, write-back, write-allocate; per line: valid bit, dirty bit, tag, BLOCK_SIZE words.
REQ-007 SHALL use addr fields: offset = [BLOCK_OFFSET_WIDTH-1:0], index = next INDEX_WIDTH bits, tag = remaining high bits.
REQ-008 SHALL implement states IDLE, RESP, WB_SETUP, WB, FILL_SETUP, FILL.
REQ-009 IDLE, cpu_req=1, hit (valid and tag match): SHALL go to RESP; read captures word into cpu_rdata; write stores cpu_wdata and sets dirty at that edge.
REQ-010 RESP: SHALL assert cpu_ready for exactly one cycle, then go to IDLE; hit latency = 1 cycle after request sampled; a request still held in IDLE the next cycle is a new request.
REQ-011 IDLE, miss: SHALL go to WB_SETUP if victim valid and dirty, else FILL_SETUP.
REQ-012 WB_SETUP / FILL_SETUP: SHALL drive mem_addr = bitwise NOT of the target block address for one cycle, guaranteeing the memory sees an address change even when target equals the last mem_addr.
REQ-013 WB: SHALL drive mem_addr = {victim tag, index, 0}, mem_we=1, mem_block_din = victim line, all stable; after the BLOCK_SIZE-th mem_valid cycle, clear dirty and go to FILL_SETUP.
REQ-014 FILL: SHALL drive mem_addr = {cpu tag, index, 0}, mem_we=0; on the k-th mem_valid cycle (k=0..BLOCK_SIZE-1) store mem_dout into word k; after the last, set tag, valid=1, dirty=0, go to IDLE (request then hits).
REQ-015 mem_we SHALL be 1 only in WB_SETUP and WB; mem_addr SHALL hold its value in IDLE and RESP (no spurious memory transaction).
REQ-016 Word counter SHALL be BLOCK_OFFSET_WIDTH+1 bits, cleared in each SETUP state, incremented per mem_valid; mem_valid outside WB/FILL SHALL be ignored.
REQ-017 cpu_ready SHALL never assert in WB_SETUP, WB, FILL_SETUP, FILL; cpu_req deassertion mid-miss is illegal and need not be handled.

Reset
REQ-018 rstn=0 at a rising edge SHALL force: state IDLE, all valid and dirty bits 0, cpu_ready 0, cpu_rdata 0, mem_we 0, mem_addr 0, counter 0; tags and data unreset.
REQ-019 Reset mid-WB or mid-FILL SHALL abort immediately; partially written memory block is accepted; cache is empty afterwards.

Verification
(memory model: BLOCK_SIZE-word streaming protocol, 16-cycle address-stable delay, word[a] = a initially)
REQ-020 Cold read 0x013 -> FILL of block 0x010, no WB, mem_we=0 throughout; cpu_ready once, cpu_rdata=0x00000013.
REQ-021 Then read 0x015 -> cpu_ready one cycle after request, cpu_rdata=0x00000015, mem_addr unchanged.
REQ-022 Write 0x015 = 0xDEADBEEF (hit), then read 0x095 (same index 2) -> WB of block 0x010 (memory word 0x015 = 0xDEADBEEF), then FILL of 0x090; cpu_rdata=0x00000095.
REQ-023 Then read 0x015 -> clean victim, no WB; FILL_SETUP drives mem_addr=~0x010 for one cycle; cpu_rdata=0xDEADBEEF.
REQ-024 rstn=0 for 1 cycle during FILL word 3 -> IDLE, cpu_ready 0, mem_we 0; next read 0x013 misses and refills.
